// File: rtl/camera_capture.sv
// OV7670-style camera bus capture: frame-aligns on VSYNC, extracts luma from the
// YUV422 byte stream and drives a linear framebuffer write port.
module camera_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int Y_FIRST     = 1,
    parameter int SKIP_FRAMES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              CLOCK_24,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [7:0]        y_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              capturing
);

    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int LINE_W = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {SYNC, SKIP, CAPTURE} state_t;

    state_t            state, state_next;
    logic [3:0]        skip_cnt, skip_next;
    logic              vsync_s1, href_s1, vsync_p, href_p;
    logic [7:0]        d_s1;
    logic              phase;
    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] line_base;
    logic              good;

    logic vsync_rise, vsync_fall, href_fall, is_y, do_write, enter_capture;

    assign vsync_rise    = vsync_s1 & ~vsync_p;
    assign vsync_fall    = ~vsync_s1 & vsync_p;
    assign href_fall     = ~href_s1 & href_p;
    assign is_y          = (Y_FIRST != 0) ? ~phase : phase;
    assign do_write      = (state == CAPTURE) && href_s1 && is_y &&
                           (col < COL_W'(H_ACTIVE)) && (line < LINE_W'(V_ACTIVE));
    assign enter_capture = (state == SYNC) && (state_next == CAPTURE);
    assign capturing     = (state == CAPTURE);

    // Input stage plus one-cycle history for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every register sees
    // pre-edge values; the async reset clears the lot the moment rst_n falls.
    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            vsync_s1 <= 1'b0;
            href_s1  <= 1'b0;
            d_s1     <= '0;
            vsync_p  <= 1'b0;
            href_p   <= 1'b0;
        end else begin
            vsync_s1 <= vsync;
            href_s1  <= href;
            d_s1     <= d;
            vsync_p  <= vsync_s1;
            href_p   <= href_s1;
        end
    end

    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            skip_cnt <= 4'(SKIP_FRAMES);
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        case (state)
            SYNC: begin
                if (vsync_fall) begin
                    if (skip_cnt != 4'd0) begin
                        skip_next  = skip_cnt - 4'd1;
                        state_next = SKIP;
                    end else begin
                        state_next = CAPTURE;
                    end
                end
            end
            SKIP:    if (vsync_rise) state_next = SYNC;
            CAPTURE: if (vsync_rise) state_next = SYNC;
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge CLOCK_24 or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            col        <= '0;
            line       <= '0;
            line_base  <= '0;
            good       <= 1'b0;
            y_data     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            phase      <= href_s1 ? ~phase : 1'b0;
            wr_en      <= do_write;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;

            if (do_write) begin
                y_data  <= d_s1;
                wr_addr <= line_base + ADDR_W'(col);
                col     <= col + COL_W'(1);
            end

            if (enter_capture) begin
                col       <= '0;
                line      <= '0;
                line_base <= '0;
                good      <= 1'b1;
            end else if (state == CAPTURE && vsync_rise) begin
                // A partial line in flight is simply never counted.
                frame_done <= 1'b1;
                frame_ok   <= good && (line == LINE_W'(V_ACTIVE));
            end else if (state == CAPTURE && href_fall) begin
                if (col != '0) begin
                    if (line < LINE_W'(V_ACTIVE)) begin
                        line      <= line + LINE_W'(1);
                        line_base <= line_base + ADDR_W'(H_ACTIVE);
                    end
                    if (col < COL_W'(H_ACTIVE)) good <= 1'b0;
                end
                col <= '0;
            end
        end
    end

endmodule
